// File: rtl/notch_sample_feeder.sv
// ADC front end for the notch filter: once per sample period it reads one serial
// two's-complement word, hands it to the filter with a sample strobe, then waits for filter_done.
module notch_sample_feeder #(
  parameter int DATA_SIZE   = 24,
  parameter int SAMPLE_DIV  = 2500,
  parameter int SCLK_HALF   = 4,
  parameter int CONV_CYCLES = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  input  logic                 adc_sdata,
  output logic [DATA_SIZE-1:0] filt_data,
  output logic                 sample,
  input  logic                 filter_done,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  localparam int PER_W  = $clog2(SAMPLE_DIV);
  localparam int PH_MAX = (CONV_CYCLES > 2 * SCLK_HALF) ? CONV_CYCLES : 2 * SCLK_HALF;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BIT_W  = $clog2(DATA_SIZE + 1);

  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SAMPLE_DIV - 1);
  localparam logic [PH_W-1:0]  CONV_LAST = PH_W'(CONV_CYCLES - 1);
  localparam logic [PH_W-1:0]  SLOT_LAST = PH_W'(2 * SCLK_HALF - 1);
  localparam logic [PH_W-1:0]  HALF_LAST = PH_W'(SCLK_HALF - 1);
  localparam logic [PH_W-1:0]  HALF     = PH_W'(SCLK_HALF);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_SIZE - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CONV      = 3'd1;
  localparam logic [2:0] SHIFT     = 3'd2;
  localparam logic [2:0] LOAD      = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;

  logic [PER_W-1:0]     per_cnt_r;
  logic                 tick_s;
  logic [2:0]           state_r, state_nx_s;
  logic [PH_W-1:0]      phase_r, phase_nx_s;
  logic [BIT_W-1:0]     bit_r, bit_nx_s;
  logic [DATA_SIZE-1:0] shift_r, shift_nx_s;
  logic                 overrun_nx_s;
  logic                 adc_cs_n_r, adc_sclk_r, sample_r, busy_r, overrun_r;
  logic [DATA_SIZE-1:0] filt_data_r;

  assign tick_s = (per_cnt_r == PER_LAST);

  // Free-running sample-period counter; it never stalls on FSM activity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt_r <= {PER_W{1'b0}};
    end else if (tick_s) begin
      per_cnt_r <= {PER_W{1'b0}};
    end else begin
      per_cnt_r <= per_cnt_r + PER_W'(1);
    end
  end

  // Next-state logic; phase_r counts CONV cycles, then clk cycles within each sclk slot.
  always_comb begin
    state_nx_s = state_r;
    phase_nx_s = phase_r;
    bit_nx_s   = bit_r;
    shift_nx_s = shift_r;
    case (state_r)
      IDLE: begin
        if (tick_s) begin
          state_nx_s = CONV;
          phase_nx_s = {PH_W{1'b0}};
        end else begin
          state_nx_s = IDLE;
        end
      end
      CONV: begin
        if (phase_r == CONV_LAST) begin
          state_nx_s = SHIFT;
          phase_nx_s = {PH_W{1'b0}};
          bit_nx_s   = {BIT_W{1'b0}};
        end else begin
          phase_nx_s = phase_r + PH_W'(1);
        end
      end
      SHIFT: begin
        if (phase_r == SLOT_LAST) begin
          phase_nx_s = {PH_W{1'b0}};
          if (bit_r == BIT_LAST) begin
            state_nx_s = LOAD;
          end else begin
            bit_nx_s = bit_r + BIT_W'(1);
          end
        end else begin
          phase_nx_s = phase_r + PH_W'(1);
          // capture on the edge where sclk rises
          if (phase_r == HALF_LAST) begin
            shift_nx_s = {shift_r[DATA_SIZE-2:0], adc_sdata};
          end else begin
            shift_nx_s = shift_r;
          end
        end
      end
      LOAD: begin
        state_nx_s = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (filter_done) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT_DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Overrun: a tick outside IDLE sets it; set beats a simultaneous clear.
  always_comb begin
    overrun_nx_s = overrun_r;
    if (tick_s && (state_r != IDLE)) begin
      overrun_nx_s = 1'b1;
    end else if (clr_overrun) begin
      overrun_nx_s = 1'b0;
    end else begin
      overrun_nx_s = overrun_r;
    end
  end

  // State registers and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      phase_r     <= {PH_W{1'b0}};
      bit_r       <= {BIT_W{1'b0}};
      shift_r     <= {DATA_SIZE{1'b0}};
      adc_cs_n_r  <= 1'b1;
      adc_sclk_r  <= 1'b0;
      sample_r    <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      filt_data_r <= {DATA_SIZE{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      phase_r    <= phase_nx_s;
      bit_r      <= bit_nx_s;
      shift_r    <= shift_nx_s;
      adc_cs_n_r <= !((state_nx_s == CONV) || (state_nx_s == SHIFT));
      adc_sclk_r <= (state_nx_s == SHIFT) && (phase_nx_s >= HALF);
      sample_r   <= (state_nx_s == LOAD);
      busy_r     <= (state_nx_s != IDLE);
      overrun_r  <= overrun_nx_s;
      if (state_nx_s == LOAD) begin
        filt_data_r <= shift_nx_s;
      end else begin
        filt_data_r <= filt_data_r;
      end
    end
  end

  assign adc_cs_n  = adc_cs_n_r;
  assign adc_sclk  = adc_sclk_r;
  assign sample    = sample_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;
  assign filt_data = filt_data_r;

endmodule
